// File: rtl/wb_slave_interface_pkg.sv
// Shared address map, default decode mask and FSM state type for the DSP
// Wishbone slave.
package wb_slave_interface_pkg;

    localparam logic [31:0] WB_REGS0      = 32'h0000_0000;
    localparam logic [31:0] WB_RAM0       = 32'h1000_0000;
    localparam logic [31:0] WB_RAM1       = 32'h1000_4000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_slave_interface.sv
// Wishbone classic slave: decodes one address window, issues a single local
// request per bus cycle and terminates it with ack, err or a local timeout.
//
// state   | meaning
// IDLE    | waiting for cyc & stb
// BUSY    | local request issued, waiting for done / timeout / abort
// RESP    | one-cycle ack or err back to the master
module wb_slave_interface
    import wb_slave_interface_pkg::*;
#(
    parameter int             dw        = 32,
    parameter int             aw        = 32,
    parameter logic [aw-1:0]  BASE_ADDR = aw'(WB_RAM0),
    parameter logic [aw-1:0]  ADDR_MASK = aw'(DEF_ADDR_MASK),
    parameter int             TIMEOUT   = 16
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic          req_o,
    output logic [aw-1:0] addr_o,
    output logic          we_o,
    output logic [3:0]    sel_o,
    output logic [dw-1:0] wdata_o,
    input  logic [dw-1:0] rdata_i,
    input  logic          done_i,
    input  logic          err_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    wb_state_e     state, state_nxt;
    logic          resp_err, resp_err_nxt;
    logic [7:0]    cnt;
    logic          accept, cnt_inc, rd_capture;
    logic          done_q, err_q;
    logic [dw-1:0] rdata_q;
    logic          addr_hit;
    logic          unused_bus_hints;

    assign unused_bus_hints = &{1'b0, wb_cti_i, wb_bte_i};

    assign addr_hit = (wb_adr_i & ADDR_MASK) == BASE_ADDR;

    always_comb begin
        state_nxt    = state;
        resp_err_nxt = resp_err;
        accept       = 1'b0;
        cnt_inc      = 1'b0;
        rd_capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (addr_hit) begin
                        accept    = 1'b1;
                        state_nxt = ST_BUSY;
                    end else begin
                        state_nxt    = ST_RESP;
                        resp_err_nxt = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (!wb_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (done_q) begin
                    state_nxt    = ST_RESP;
                    resp_err_nxt = err_q;
                    rd_capture   = !err_q && !we_o;
                end else if (cnt == TO_LAST) begin
                    state_nxt    = ST_RESP;
                    resp_err_nxt = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt    = ST_IDLE;
                resp_err_nxt = 1'b0;
            end
            default: begin
                state_nxt    = ST_IDLE;
                resp_err_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= ST_IDLE;
            resp_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            resp_err <= resp_err_nxt;
        end
    end

    // Local response is registered once; only a done seen while the cycle is
    // still live in BUSY is kept, so late done pulses never leak into a new cycle.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= (state == ST_BUSY) && wb_cyc_i && !done_q && done_i;
            if ((state == ST_BUSY) && done_i) begin
                err_q   <= err_i;
                rdata_q <= rdata_i;
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            req_o    <= 1'b0;
            addr_o   <= '0;
            we_o     <= 1'b0;
            sel_o    <= '0;
            wdata_o  <= '0;
            wb_dat_o <= '0;
            cnt      <= '0;
        end else begin
            req_o <= accept;
            if (accept) begin
                addr_o  <= wb_adr_i & ~ADDR_MASK;
                we_o    <= wb_we_i;
                sel_o   <= wb_sel_i;
                wdata_o <= wb_dat_i;
                cnt     <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 8'd1;
            end
            if (rd_capture) begin
                wb_dat_o <= rdata_q;
            end
        end
    end

    assign wb_ack_o = (state == ST_RESP) && !resp_err;
    assign wb_err_o = (state == ST_RESP) && resp_err;
    assign wb_rty_o = 1'b0;

`ifdef SIM
    string state_name;
    always_comb state_name = state.name();
`endif

endmodule

// File: tb/tb_wb_slave_interface.sv
// Directed bench for wb_slave_interface: hit/miss decode, wait states,
// timeout, abort, back-to-back cycles and asynchronous reset.
module tb_wb_slave_interface;
    import wb_slave_interface_pkg::*;

    localparam logic [31:0] BASE = WB_RAM0;

    logic        wb_clk;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        req_o;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;
    logic        done_i;
    logic        err_i;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int r0, a0, e0;

    wb_slave_interface #(
        .dw(32), .aw(32), .BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_F000), .TIMEOUT(16)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .sel_o(sel_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i), .done_i(done_i), .err_i(err_i)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) begin
        if (req_o) req_cnt++;
        if (wb_ack_o) ack_cnt++;
        if (wb_err_o) err_cnt++;
        if (wb_ack_o && wb_err_o) both_cnt++;
    end

    task automatic tick;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_start(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    task automatic bus_end;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    initial begin
        wb_rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b111; wb_bte_i = 2'b11;
        rdata_i = '0; done_i = 1'b0; err_i = 1'b0;
        tick; tick;
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_ack_err_rty_req", {28'h0, wb_ack_o, wb_err_o, wb_rty_o, req_o}, 32'h0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_we_sel", {27'h0, we_o, sel_o}, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        wb_rst_n = 1'b1;
        tick;

        // write hit, done in the same cycle as req
        r0 = req_cnt; a0 = ack_cnt;
        bus_start(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        tick;
        chk("wr_req", {31'h0, req_o}, 32'h1);
        chk("wr_addr", addr_o, 32'h10);
        chk("wr_wdata", wdata_o, 32'hDEADBEEF);
        chk("wr_we_sel", {27'h0, we_o, sel_o}, {27'h0, 1'b1, 4'hF});
        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        chk("wr_req_single", {31'h0, req_o}, 32'h0);
        chk("wr_no_early_ack", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        tick;
        chk("wr_ack", {30'h0, wb_ack_o, wb_err_o}, 32'h2);
        bus_end;
        tick;
        chk("wr_ack_one_cycle", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        chk("wr_dat_unchanged", wb_dat_o, 32'h0);
        chk("wr_counts", (req_cnt - r0) * 16 + (ack_cnt - a0), 32'h11);

        // read with 3 wait cycles
        bus_start(BASE + 32'h24, 32'h0, 4'h3, 1'b0);
        tick;
        chk("rd_req_addr", addr_o, 32'h24);
        chk("rd_we_sel", {27'h0, we_o, sel_o}, {27'h0, 1'b0, 4'h3});
        tick; tick; tick;
        chk("rd_waiting", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        done_i = 1'b1; rdata_i = 32'h12345678;
        tick;
        done_i = 1'b0; rdata_i = 32'h0;
        chk("rd_not_yet", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        tick;
        chk("rd_ack", {30'h0, wb_ack_o, wb_err_o}, 32'h2);
        chk("rd_dat", wb_dat_o, 32'h12345678);
        bus_end;
        tick;
        chk("rd_ack_one_cycle", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        tick;
        chk("rd_dat_held", wb_dat_o, 32'h12345678);

        // miss
        r0 = req_cnt; e0 = err_cnt;
        bus_start(BASE + 32'h1000, 32'h5555AAAA, 4'hF, 1'b0);
        tick;
        chk("miss_err", {30'h0, wb_ack_o, wb_err_o}, 32'h1);
        chk("miss_no_req", {31'h0, req_o}, 32'h0);
        bus_end;
        tick;
        chk("miss_err_one_cycle", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        chk("miss_counts", (req_cnt - r0) * 16 + (err_cnt - e0), 32'h01);
        chk("miss_dat_unchanged", wb_dat_o, 32'h12345678);

        // timeout: err 16 cycles after req
        bus_start(BASE + 32'h40, 32'h0, 4'hF, 1'b0);
        tick;
        chk("to_req", {31'h0, req_o}, 32'h1);
        for (int k = 1; k < 16; k++) begin
            tick;
            chk("to_waiting", {30'h0, wb_ack_o, wb_err_o}, 32'h0);
        end
        tick;
        chk("to_err", {30'h0, wb_ack_o, wb_err_o}, 32'h1);
        bus_end;
        tick;
        chk("to_idle", {29'h0, wb_ack_o, wb_err_o, req_o}, 32'h0);

        // abort in BUSY, late done ignored
        r0 = req_cnt; a0 = ack_cnt; e0 = err_cnt;
        bus_start(BASE + 32'h30, 32'h0, 4'hF, 1'b0);
        tick;
        bus_end;
        tick;
        done_i = 1'b1; rdata_i = 32'hBAD0BAD0;
        tick;
        done_i = 1'b0; rdata_i = 32'h0;
        tick; tick; tick;
        chk("abort_counts", (req_cnt - r0) * 256 + (ack_cnt - a0) * 16 + (err_cnt - e0), 32'h100);
        chk("abort_dat", wb_dat_o, 32'h12345678);

        // back-to-back read then write
        r0 = req_cnt; a0 = ack_cnt;
        bus_start(BASE + 32'h20, 32'h0, 4'hF, 1'b0);
        tick;
        done_i = 1'b1; rdata_i = 32'hCAFEF00D;
        tick;
        done_i = 1'b0; rdata_i = 32'h0;
        tick;
        chk("b2b_rd_ack", {30'h0, wb_ack_o, wb_err_o}, 32'h2);
        chk("b2b_rd_dat", wb_dat_o, 32'hCAFEF00D);
        bus_start(BASE + 32'h28, 32'hA5A5_0F0F, 4'hC, 1'b1);
        tick;
        chk("b2b_gap", {29'h0, wb_ack_o, wb_err_o, req_o}, 32'h0);
        tick;
        chk("b2b_wr_req", {31'h0, req_o}, 32'h1);
        chk("b2b_wr_addr", addr_o, 32'h28);
        chk("b2b_wr_wdata", wdata_o, 32'hA5A50F0F);
        chk("b2b_wr_we_sel", {27'h0, we_o, sel_o}, {27'h0, 1'b1, 4'hC});
        done_i = 1'b1;
        tick;
        done_i = 1'b0;
        tick;
        chk("b2b_wr_ack", {30'h0, wb_ack_o, wb_err_o}, 32'h2);
        bus_end;
        tick;
        chk("b2b_counts", (req_cnt - r0) * 16 + (ack_cnt - a0), 32'h22);
        chk("b2b_dat_after_wr", wb_dat_o, 32'hCAFEF00D);

        // reset asserted mid-BUSY
        bus_start(BASE + 32'h50, 32'h1111_2222, 4'hF, 1'b1);
        tick;
        chk("rstb_req", {31'h0, req_o}, 32'h1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        chk("rstb_dat", wb_dat_o, 32'h0);
        chk("rstb_flags", {28'h0, wb_ack_o, wb_err_o, wb_rty_o, req_o}, 32'h0);
        chk("rstb_addr", addr_o, 32'h0);
        chk("rstb_we_sel", {27'h0, we_o, sel_o}, 32'h0);
        chk("rstb_wdata", wdata_o, 32'h0);
        bus_end;
        tick;
        wb_rst_n = 1'b1;
        tick; tick;
        chk("rstb_idle", {29'h0, wb_ack_o, wb_err_o, req_o}, 32'h0);
        chk("never_ack_and_err", both_cnt, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
